back_propagation_node_serial_mac: RTL and testbench

Back-propagation node for the fp32 DQN datapath. It takes a serial stream of (delta, weight) pairs, multiplies each pair, and accumulates NUM_TERMS products into one error term for a hidden-layer node. Generalises the fixed 24-input back-propagation node with a runtime-free parametrised term count, ready/valid backpressure, and group-overlapped streaming. It sits between the output/hidden delta generators and the weight-update stage.

---
 rtl/back_propagation_node_serial_mac.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_back_propagation_node_serial_mac.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/back_propagation_node_serial_mac.sv
// Serial fp32 multiply-accumulate back-propagation node with credit-based input flow control.
// Optional ReLU-derivative gating of each group output: define BP_NODE_RELU_GRAD_EN.

module multiplier_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] prod_o
);
    logic [LATENCY-1:0] vld_q;
    logic [31:0]        dat_q [LATENCY];

    // Round-to-nearest-even; denormal operands and results flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sg;
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [47:0]       p;
        logic [23:0]       m;
        logic              g;
        logic              st;
        logic              up;
        logic [24:0]       mr;
        logic signed [10:0] e;
        sg = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0))
            return 32'h7FC00000;
        if (ea == 8'hFF || eb == 8'hFF)
            return (ea == 8'h00 || eb == 8'h00) ? 32'h7FC00000 : {sg, 8'hFF, 23'h0};
        if (ea == 8'h00 || eb == 8'h00)
            return {sg, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        up = g & (st | m[0]);
        mr = {1'b0, m} + 25'(up);
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 11'sd1;
        end else begin
            m = mr[23:0];
        end
        if (e >= 11'sd255)
            return {sg, 8'hFF, 23'h0};
        if (e <= 11'sd0)
            return {sg, 31'h0};
        return {sg, e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= fp_mul(a_i, b_i);
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign prod_o  = dat_q[LATENCY-1];
endmodule

module adder_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] sum_o
);
    logic [LATENCY-1:0] vld_q;
    logic [31:0]        dat_q [LATENCY];

    // Three extra bits (guard, round, sticky) carry the alignment loss into rounding.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x;
        logic [31:0]       y;
        logic [26:0]       mx;
        logic [26:0]       my;
        logic [26:0]       ms;
        logic [26:0]       m;
        logic [53:0]       sh;
        logic [27:0]       s;
        logic [7:0]        d;
        logic [4:0]        lz;
        logic              found;
        logic              up;
        logic [24:0]       mr;
        logic signed [9:0] e;
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
            return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (a[30:23] == 8'hFF)
            return a;
        if (b[30:23] == 8'hFF)
            return b;
        if (a[30:23] == 8'h00)
            return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
        if (b[30:23] == 8'h00)
            return a;
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = x[30:23] - y[30:23];
        if (d > 8'd27)
            d = 8'd27;
        sh = {my, 27'h0} >> d;
        ms = sh[53:27] | {26'h0, |sh[26:0]};
        e  = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, ms};
            if (s[27]) begin
                m = {s[27:2], s[1] | s[0]};
                e = e + 10'sd1;
            end else begin
                m = s[26:0];
            end
        end else begin
            m = mx - ms;
            if (m == '0)
                return 32'h00000000;
            lz    = '0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (m[i])
                        found = 1'b1;
                    else
                        lz = lz + 5'd1;
                end
            end
            m = m << lz;
            e = e - $signed({5'b00000, lz});
        end
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[26:3]} + 25'(up);
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (e >= 10'sd255)
            return {x[31], 8'hFF, 23'h0};
        if (e <= 10'sd0)
            return {x[31], 31'h0};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= fp_add(a_i, b_i);
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign sum_o   = dat_q[LATENCY-1];
endmodule

module back_propagation_node_serial_mac #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_TERMS   = 24,
    parameter int MUL_LATENCY = 7,
    parameter int ADD_LATENCY = 7,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef BP_NODE_RELU_GRAD_EN
    input  logic                  i_relu_active,
`endif
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_delta,
    input  logic [DATA_WIDTH-1:0] i_weight,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(NUM_TERMS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] prod_q;
    logic [DATA_WIDTH-1:0] add_a_q;
    logic [DATA_WIDTH-1:0] add_b_q;
    logic                  add_v_q;
    logic [TW-1:0]         term_cnt_q;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q;
    logic                  o_ready_q;
    logic                  ready_d;

    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         fifo_cnt_q;
    logic [CW-1:0]         out_cnt_q;
    logic [CW-1:0]         out_cnt_d;

    logic                  accept;
    logic                  pop;
    logic                  mul_v;
    logic [DATA_WIDTH-1:0] mul_p;
    logic                  add_v;
    logic [DATA_WIDTH-1:0] add_s;
    logic                  relu_keep;

    assign accept = i_valid && o_ready_q;
    assign pop    = (state_q == S_IDLE) && (fifo_cnt_q != '0);

    multiplier_floating_point32 #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .a_i     (i_delta),
        .b_i     (i_weight),
        .valid_o (mul_v),
        .prod_o  (mul_p)
    );

    adder_floating_point32 #(.LATENCY(ADD_LATENCY)) u_add (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (add_v_q),
        .a_i     (add_a_q),
        .b_i     (add_b_q),
        .valid_o (add_v),
        .sum_o   (add_s)
    );

    // Credits cover both buffered and in-multiplier products, so a push never finds the FIFO full.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (accept)
            out_cnt_d = out_cnt_d + 1'b1;
        if (pop)
            out_cnt_d = out_cnt_d - 1'b1;
    end

`ifdef BP_NODE_RELU_GRAD_EN
    logic [1:0]    rq_q;
    logic          rq_wr_q;
    logic          rq_rd_q;
    logic [1:0]    rq_cnt_q;
    logic [1:0]    rq_cnt_d;
    logic [TW-1:0] in_cnt_q;
    logic [TW-1:0] in_cnt_d;
    logic          grp_first;
    logic          grp_done;

    assign grp_first = accept && (in_cnt_q == '0);
    assign grp_done  = (state_q == S_DONE);
    assign relu_keep = rq_q[rq_rd_q];

    always_comb begin
        in_cnt_d = in_cnt_q;
        if (accept)
            in_cnt_d = (in_cnt_q == TW'(NUM_TERMS - 1)) ? '0 : in_cnt_q + 1'b1;
        rq_cnt_d = rq_cnt_q;
        if (grp_first)
            rq_cnt_d = rq_cnt_d + 2'd1;
        if (grp_done)
            rq_cnt_d = rq_cnt_d - 2'd1;
    end

    // A new group may only start while a gating slot is free.
    assign ready_d = (out_cnt_d < CW'(FIFO_DEPTH))
                  && !((in_cnt_d == '0) && (rq_cnt_d == 2'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_q     <= '0;
            rq_wr_q  <= 1'b0;
            rq_rd_q  <= 1'b0;
            rq_cnt_q <= '0;
            in_cnt_q <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
            rq_cnt_q <= rq_cnt_d;
            if (grp_first) begin
                rq_q[rq_wr_q] <= i_relu_active;
                rq_wr_q       <= ~rq_wr_q;
            end
            if (grp_done)
                rq_rd_q <= ~rq_rd_q;
        end
    end
`else
    assign relu_keep = 1'b1;
    assign ready_d   = (out_cnt_d < CW'(FIFO_DEPTH));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            o_ready_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_q[i] <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            o_ready_q <= ready_d;
            if (mul_v) begin
                fifo_q[wr_ptr_q] <= mul_p;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (mul_v && !pop)
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!mul_v && pop)
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            prod_q     <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_v_q    <= 1'b0;
            term_cnt_q <= '0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            add_v_q   <= 1'b0;
            o_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        prod_q  <= fifo_q[rd_ptr_q];
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    add_a_q <= acc_q;
                    add_b_q <= prod_q;
                    add_v_q <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (add_v) begin
                        acc_q      <= add_s;
                        term_cnt_q <= term_cnt_q + 1'b1;
                        if (term_cnt_q == TW'(NUM_TERMS - 1))
                            state_q <= S_DONE;
                        else
                            state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    o_data_q   <= relu_keep ? acc_q : '0;
                    o_valid_q  <= 1'b1;
                    acc_q      <= '0;
                    term_cnt_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready = o_ready_q;
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_busy  = (out_cnt_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_back_propagation_node_serial_mac.sv
// Directed and scoreboarded bench for back_propagation_node_serial_mac.
// Three instances: NUM_TERMS = 4 (A), 24 (B) and 1 (C).

module tb_back_propagation_node_serial_mac;
    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_ovalid, a_busy;
    logic [31:0] a_delta, a_weight, a_data;
    logic        b_valid, b_ready, b_ovalid, b_busy;
    logic [31:0] b_delta, b_weight, b_data;
    logic        c_valid, c_ready, c_ovalid, c_busy;
    logic [31:0] c_delta, c_weight, c_data;
`ifdef BP_NODE_RELU_GRAD_EN
    logic        a_relu;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          b_stall = 0;
    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    logic [31:0] got_c[$];
    logic [31:0] exp_a[$];

    logic [31:0] dtab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] wtab [5] = '{32'h3F000000, 32'hBF000000, 32'h3F800000,
                              32'h40000000, 32'hC0000000};
    int          whalf [5] = '{1, -1, 2, 4, -4};

    back_propagation_node_serial_mac #(.NUM_TERMS(4)) u_a (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef BP_NODE_RELU_GRAD_EN
        .i_relu_active (a_relu),
`endif
        .i_valid       (a_valid),
        .o_ready       (a_ready),
        .i_delta       (a_delta),
        .i_weight      (a_weight),
        .o_data        (a_data),
        .o_valid       (a_ovalid),
        .o_busy        (a_busy)
    );

    back_propagation_node_serial_mac #(.NUM_TERMS(24)) u_b (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef BP_NODE_RELU_GRAD_EN
        .i_relu_active (1'b1),
`endif
        .i_valid       (b_valid),
        .o_ready       (b_ready),
        .i_delta       (b_delta),
        .i_weight      (b_weight),
        .o_data        (b_data),
        .o_valid       (b_ovalid),
        .o_busy        (b_busy)
    );

    back_propagation_node_serial_mac #(.NUM_TERMS(1)) u_c (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef BP_NODE_RELU_GRAD_EN
        .i_relu_active (1'b1),
`endif
        .i_valid       (c_valid),
        .o_ready       (c_ready),
        .i_delta       (c_delta),
        .i_weight      (c_weight),
        .o_data        (c_data),
        .o_valid       (c_ovalid),
        .o_busy        (c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_ovalid) got_a.push_back(a_data);
        if (b_ovalid) got_b.push_back(b_data);
        if (c_ovalid) got_c.push_back(c_data);
        if (b_valid && !b_ready) b_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Half-unit integer sum to fp32; exact for the small magnitudes used here.
    function automatic logic [31:0] half_to_fp(input int s);
        logic        sg;
        int          m;
        int          e;
        logic [7:0]  ex;
        logic [22:0] fr;
        if (s == 0)
            return 32'h00000000;
        sg = (s < 0);
        m  = sg ? -s : s;
        e  = 0;
        while ((m >> (e + 1)) != 0)
            e++;
        ex = 8'(e + 126);
        fr = 23'(m << (23 - e));
        return {sg, ex, fr};
    endfunction

    task automatic send_a(input logic [31:0] d, input logic [31:0] w, input int gap_pct);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(negedge clk);
            a_delta  = d;
            a_weight = w;
            a_valid  = ($urandom_range(99) >= gap_pct);
            done     = a_valid && a_ready;
            guard++;
            if (guard > 1000) begin
                $display("FAIL a_ready_timeout: ready %b after %0d cycles", a_ready, guard);
                $fatal(1);
            end
        end
        @(posedge clk);
    endtask

    task automatic send_b(input logic [31:0] d, input logic [31:0] w);
        int guard = 0;
        @(negedge clk);
        b_delta  = d;
        b_weight = w;
        b_valid  = 1'b1;
        while (!b_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                $display("FAIL b_ready_timeout: ready %b", b_ready);
                $fatal(1);
            end
        end
        @(posedge clk);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((a_busy || b_busy || c_busy) && n < lim);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s;
        int di;
        int wi;
        int lat;
        rst_n = 1'b0;
        a_valid = 1'b0; a_delta = '0; a_weight = '0;
        b_valid = 1'b0; b_delta = '0; b_weight = '0;
        c_valid = 1'b0; c_delta = '0; c_weight = '0;
`ifdef BP_NODE_RELU_GRAD_EN
        a_relu = 1'b1;
`endif
        #12;
        chk("rst_ready", {31'h0, a_ready}, 32'h0);
        chk("rst_data", a_data, 32'h0);
        chk("rst_busy", {31'h0, a_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_ready", {31'h0, a_ready}, 32'h1);

        // Reset with five terms in flight.
        for (int i = 0; i < 5; i++)
            send_a(32'h3F800000, 32'h3F000000, 0);
        @(negedge clk);
        a_valid = 1'b0;
        chk("pre_rst_busy", {31'h0, a_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", a_data, 32'h0);
        chk("mid_rst_valid", {31'h0, a_ovalid}, 32'h0);
        chk("mid_rst_busy", {31'h0, a_busy}, 32'h0);
        chk("mid_rst_ready", {31'h0, a_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", {31'h0, a_ready}, 32'h1);
        chk("post_rst_busy", {31'h0, a_busy}, 32'h0);
        repeat (60) @(negedge clk);
        chk("post_rst_pulses", got_a.size(), 0);

        // Two back-to-back groups of four.
        for (int i = 0; i < 4; i++)
            send_a(dtab[i], 32'h3F000000, 0);
        for (int i = 0; i < 4; i++)
            send_a(32'h40400000, 32'hC0000000, 0);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle(500);
        chk("g4_count", got_a.size(), 2);
        chk("g4_first", got_a[0], 32'h40A00000);
        chk("g4_second", got_a[1], 32'hC1C00000);
        got_a.delete();

        // 24-term group with valid held high.
        for (int i = 0; i < 24; i++)
            send_b(32'h3F800000, 32'h3F000000);
        @(negedge clk);
        b_valid = 1'b0;
        wait_idle(1000);
        chk("g24_count", got_b.size(), 1);
        chk("g24_sum", got_b[0], 32'h41400000);
        chk("g24_stalled", {31'h0, b_stall > 0}, 32'h1);
        chk("g24_busy", {31'h0, b_busy}, 32'h0);

        // Single-term latency from the accept edge.
        @(negedge clk);
        c_delta  = 32'h40400000;
        c_weight = 32'hC0000000;
        c_valid  = 1'b1;
        chk("g1_ready", {31'h0, c_ready}, 32'h1);
        @(posedge clk);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            c_valid = 1'b0;
            if (c_ovalid) break;
            @(posedge clk);
            lat++;
        end
        chk("g1_latency", lat, 18);
        chk("g1_data", c_data, 32'hC0C00000);
        wait_idle(200);
        chk("g1_count", got_c.size(), 1);

`ifdef BP_NODE_RELU_GRAD_EN
        a_relu = 1'b0;
        for (int i = 0; i < 4; i++)
            send_a(32'h3F800000, 32'h3F800000, 0);
        a_relu = 1'b1;
        for (int i = 0; i < 4; i++)
            send_a(32'h3F800000, 32'h3F800000, 0);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle(500);
        chk("relu_count", got_a.size(), 2);
        chk("relu_off", got_a[0], 32'h00000000);
        chk("relu_on", got_a[1], 32'h40800000);
        got_a.delete();
`endif

        // Random gaps and backpressure over 1000 groups.
        for (int g = 0; g < 1000; g++) begin
            s = 0;
            for (int t = 0; t < 4; t++) begin
                di = $urandom_range(7);
                wi = $urandom_range(4);
                s += (di + 1) * whalf[wi];
                send_a(dtab[di], wtab[wi], 30);
            end
            exp_a.push_back(half_to_fp(s));
        end
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle(2000);
        chk("bp_busy", {31'h0, a_busy}, 32'h0);
        chk("bp_count", got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            chk("bp_group", (i < got_a.size()) ? got_a[i] : 32'hDEADBEEF, exp_a[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
